// File: rtl/sram_pkg.sv
// Shared types and widths for the SRAM arbiter.
// The state list is the single access FSM's encoding.
package sram_pkg;

  localparam int SRAM_AW = 21;
  localparam int SRAM_DW = 8;

  typedef enum logic [2:0] {
    IDLE,
    VRD_A,
    VRD_B,
    CRD_A,
    CRD_B,
    CWR_A,
    CWR_B,
    CWR_C
  } state_t;

endpackage

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between non-interruptible video bursts
// and single-byte CPU reads/writes, alternating grants under contention.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int VID_BURST = 8
) (
  input  logic               clk_sram,
  input  logic               rst_n,
  input  logic               vid_req,
  input  logic [SRAM_AW-1:0] vid_addr,
  output logic [SRAM_DW-1:0] vid_data,
  output logic               vid_valid,
  output logic               vid_done,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [SRAM_AW-1:0] cpu_addr,
  input  logic [SRAM_DW-1:0] cpu_wdata,
  output logic [SRAM_DW-1:0] cpu_rdata,
  output logic               cpu_ack,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DW-1:0] SRAM_DATA,
  output logic               SRAM_WE_n
);

  localparam int CW = 7;
  localparam logic [CW-1:0] LAST = CW'(VID_BURST - 1);

  state_t             state;
  state_t             state_nx;
  logic [CW-1:0]      cnt;
  logic [SRAM_DW-1:0] wdata_q;
  logic               last_vid;
  logic               elig_v;
  logic               elig_c;
  logic               pick_v;
  logic               grant_v;
  logic               grant_c;
  logic               last_byte;
  logic               drive;

  // a requester whose completion pulse is high is already served
  assign elig_v    = vid_req & ~vid_done;
  assign elig_c    = cpu_req & ~cpu_ack;
  assign pick_v    = elig_v & (~elig_c | ~last_vid);
  assign grant_v   = (state == IDLE) & pick_v;
  assign grant_c   = (state == IDLE) & elig_c & ~pick_v;
  assign last_byte = (cnt == LAST);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (grant_v)
          state_nx = VRD_A;
        else if (grant_c)
          state_nx = cpu_we ? CWR_A : CRD_A;
      end
      VRD_A:   state_nx = VRD_B;
      VRD_B:   state_nx = last_byte ? IDLE : VRD_A;
      CRD_A:   state_nx = CRD_B;
      CRD_B:   state_nx = IDLE;
      CWR_A:   state_nx = CWR_B;
      CWR_B:   state_nx = CWR_C;
      CWR_C:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sram or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk_sram or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      last_vid  <= 1'b0;
      wdata_q   <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_n <= 1'b1;
    end else begin
      SRAM_WE_n <= (state_nx != CWR_B);
      if (grant_v) begin
        cnt       <= '0;
        SRAM_ADDR <= vid_addr;
        last_vid  <= 1'b1;
      end else if (grant_c) begin
        SRAM_ADDR <= cpu_addr;
        wdata_q   <= cpu_wdata;
        last_vid  <= 1'b0;
      end else if (state == VRD_B && !last_byte) begin
        cnt       <= cnt + CW'(1);
        SRAM_ADDR <= SRAM_ADDR + SRAM_AW'(1);
      end
    end
  end

  always_ff @(posedge clk_sram or negedge rst_n) begin
    if (!rst_n) begin
      vid_valid <= 1'b0;
      vid_done  <= 1'b0;
      vid_data  <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      vid_valid <= (state == VRD_B);
      vid_done  <= (state == VRD_B) & last_byte;
      cpu_ack   <= (state == CRD_B) | (state == CWR_C);
      if (state == VRD_B)
        vid_data <= SRAM_DATA;
      if (state == CRD_B)
        cpu_rdata <= SRAM_DATA;
    end
  end

  assign drive     = (state == CWR_A) | (state == CWR_B) | (state == CWR_C);
  assign SRAM_DATA = drive ? wdata_q : {SRAM_DW{1'bz}};

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: VID_BURST, 8, bytes per video burst (legal range 1..64).
REQ-002 Port: clk_sram  in  1  SRAM controller clock; all logic on its rising edge.
REQ-003 Port: rst_n  in  1  asynchronous active-low reset.
REQ-004 Port: vid_req  in  1  video burst request, level, held until vid_done.
REQ-005 Port: vid_addr  in  21  burst start byte address, sampled at grant.
REQ-006 Port: vid_data  out  8  video read byte, valid when vid_valid=1.
REQ-007 Port: vid_valid  out  1  one-cycle strobe per byte delivered.
REQ-008 Port: vid_done  out  1  one-cycle pulse, coincident with the last vid_valid.
REQ-009 Port: cpu_req  in  1  CPU access request, level, held until cpu_ack.
REQ-010 Port: cpu_we  in  1  1=write, 0=read; sampled at grant with cpu_addr and cpu_wdata.
REQ-011 Port: cpu_addr  in  21  CPU byte address.
REQ-012 Port: cpu_wdata  in  8  CPU write byte.
REQ-013 Port: cpu_rdata  out  8  CPU read byte, valid when cpu_ack=1 on a read.
REQ-014 Port: cpu_ack  out  1  one-cycle completion pulse.
REQ-015 Port: SRAM_ADDR  out  21  registered SRAM address.
REQ-016 Port: SRAM_DATA  inout  8  SRAM data bus; driven only during write states, else high-Z.
REQ-017 Port: SRAM_WE_n  out  1  registered active-low write enable.

Function
REQ-018 States SHALL be IDLE, VRD_A, VRD_B, CRD_A, CRD_B, CWR_A, CWR_B, CWR_C.
REQ-019 Read access = 2 cycles: _A drives SRAM_ADDR with WE_n=1; SRAM_DATA is registered on the edge leaving _B.
REQ-020 Write access = 3 cycles: CWR_A address+data driven, WE_n=1; CWR_B WE_n=0; CWR_C WE_n=1, address and data held.
REQ-021 IDLE with one eligible request -> grant it: VRD_A for video; CRD_A or CWR_A per cpu_we.
REQ-022 IDLE with both eligible -> grant the requester not granted last; after reset, video wins.
REQ-023 A requester is ineligible in any cycle its vid_done or cpu_ack is high, which prevents a double grant.
REQ-024 A video burst is non-interruptible: VRD_B -> VRD_A until VID_BURST bytes are read, then IDLE.
REQ-025 Burst address increments by 1 per byte modulo 2^21: 0x1FFFFF wraps to 0x000000.
REQ-026 vid_valid/vid_data are registered and high in the cycle after each VRD_B; a burst occupies 2*VID_BURST cycles.
REQ-027 vid_done SHALL equal vid_valid of byte VID_BURST-1 and assert only then.
REQ-028 cpu_ack is high in the cycle after CRD_B or CWR_C; cpu_rdata is updated only by reads and holds otherwise.
REQ-029 Grant-to-ack latency: read 3 cycles, write 4 cycles, measured from the IDLE cycle that grants.
REQ-030 Changes to request inputs during an access SHALL have no effect on that access.
REQ-031 SRAM_DATA SHALL be driven only in CWR_A/B/C; SRAM_ADDR SHALL NOT change while WE_n=0.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, SRAM_WE_n=1, SRAM_DATA high-Z, SRAM_ADDR=0, and vid_valid, vid_done, cpu_ack, vid_data, cpu_rdata = 0.
REQ-033 Reset mid-operation SHALL abort the access without a completion pulse; last-grant history SHALL clear to "video wins".

Structure
REQ-034 Shared package sram_pkg SHALL hold SRAM_AW=21, SRAM_DW=8 and the state enumeration.
REQ-035 No sub-module; one single-clock module with one FSM, a burst counter and an address register.

Verification
REQ-036 vid_req, vid_addr=0x000100, VID_BURST=8 -> 8 vid_valid strobes 2 cycles apart with bytes from 0x100..0x107; vid_done on the 8th strobe.
REQ-037 cpu_we=1, cpu_addr=0x1ABCDE, cpu_wdata=0x5A; then a read of the same address -> WE_n low exactly 1 cycle with address stable; cpu_rdata=0x5A, ack 3 cycles after grant.
REQ-038 vid_req and cpu_req asserted in the same cycle from reset -> video burst first, CPU granted in the IDLE after vid_done, then video again.
REQ-039 vid_addr=0x1FFFFE, burst 4 -> addresses 0x1FFFFE, 0x1FFFFF, 0x000000, 0x000001.
REQ-040 rst_n low during CWR_B -> SRAM_WE_n=1 and SRAM_DATA high-Z without a clock edge; no cpu_ack; FSM in IDLE.
REQ-041 cpu_req held one cycle past cpu_ack -> exactly one access performed.
